dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port synchronous data memory (1024 x 32-bit words, 1-cycle registered read, read-before-write).
- Port A is the CPU load/store unit; port B is the debug/loader port.
- Accepts one request at a time through a valid/ready handshake, drives the memory, captures read data and returns a response.
- Out-of-range addresses are rejected with an error response and never reach memory.

Parameters:
- ADDR_W, 32, width of request and memory word address
- DATA_W, 32, data width
- DEPTH, 1024, number of memory words; legal addresses are 0..DEPTH-1
- FAIR, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- a_req_valid  in  1  port A request valid
- a_req_ready  out  1  port A request accepted this cycle
- a_req_we  in  1  1 = write, 0 = read
- a_req_addr  in  ADDR_W  word address
- a_req_wdata  in  DATA_W  write data
- a_rsp_valid  out  1  port A response valid
- a_rsp_ready  in  1  port A response consumed
- a_rsp_rdata  out  DATA_W  read data (old word for writes)
- a_rsp_err  out  1  address out of range
- b_*  (same 9 signals for port B)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address is presented

Behaviour:
- **Reset (rst_n=0 at posedge):**
  - state=IDLE; all rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Internal command registers (mem_addr, mem_wdata) = 0; last_grant=B, so A wins the first tie.
  - mem_we is combinationally gated by rst_n: no memory write occurs in any cycle with rst_n=0.
  - Reset mid-operation aborts the transaction; the response is discarded.
- **Handshake:** a request transfers when req_valid & req_ready. A requester keeps valid and all fields stable until ready. Only one transaction is outstanding.
- **req_ready:** asserted combinationally only in IDLE, only to the grant winner; never to both.
- **Arbitration (IDLE):**
  - FAIR=1: a single requester wins; if both request, the one not equal to last_grant wins. last_grant updates on accept.
  - FAIR=0: A wins any tie.
- **FSM:**
  - IDLE: on accept, latch owner, we, addr, wdata. If addr >= DEPTH, go to RESP with err=1, rdata=0. Otherwise go to MEM.
  - MEM (1 cycle): mem_addr and mem_wdata hold the latched values; mem_we = latched we. Go to CAP.
  - CAP (1 cycle): mem_we=0; capture mem_rdata into the owner's rsp_rdata; err=0. Go to RESP.
  - RESP: owner's rsp_valid=1; rdata and err stable. When rsp_ready=1, clear rsp_valid at the next edge and go to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- **Latency:**
  - Accept edge to rsp_valid high: 3 cycles for a legal address, 1 cycle for an error.
  - Best-case throughput: one transaction per 4 cycles.
- **Idle memory signals:** mem_we=0 outside MEM; mem_addr and mem_wdata hold their last values.
- **Address check:** unsigned compare of the full ADDR_W bits against DEPTH. Address DEPTH-1 is legal; address DEPTH is an error.
- The non-owner port keeps rsp_valid=0 and req_ready=0 throughout a transaction.

Test Plan:
- **Reset then A write:** A writes addr 5, data 0xDEADBEEF → mem_we high for exactly 1 cycle with mem_addr=5. a_rsp_valid rises 3 cycles after accept. A subsequent A read of addr 5 returns 0xDEADBEEF, err=0.
- **Simultaneous requests, FAIR=1:** A and B both request reads continuously → grants alternate A, B, A, B; A gets the first grant after reset. With FAIR=0 → A, A, A; B starves.
- **Range boundary:** B reads addr 1023 → err=0, data returned. B reads addr 1024 and 0xFFFFFFFF → err=1, rdata=0, mem_we never asserted, rsp 1 cycle after accept.
- **Response backpressure:** a_rsp_ready held low 5 cycles → rsp_valid and rdata held stable. B valid during this time is not granted. After the A response handshake, B is granted no earlier than the following cycle.
- **Write returns old data:** addr 7 holds 0x11; A writes 0x22 → a_rsp_rdata=0x11. A read of addr 7 then returns 0x22.
- **Reset mid-operation:** rst_n low in the MEM cycle of a write to addr 9 → mem_we=0 that cycle, addr 9 unchanged. After release, all rsp_valid=0 and the next request is granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter/sequencer in front of a single-port synchronous data
// memory (registered 1-cycle read, read-before-write). One transaction is
// outstanding at a time; out-of-range addresses get an error response and
// never touch the memory.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   a_req_* / b_req_*     request channel (valid/ready, we, addr, wdata);
//                         A = CPU load/store unit, B = debug/loader
//   a_rsp_* / b_rsp_*     response channel (valid/ready, rdata, err)
//   mem_addr/wdata/we     memory command outputs
//   mem_rdata             memory read data, valid the cycle after the address
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_rdata,
    output logic              a_rsp_err,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_rdata,
    output logic              b_rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_CAP, S_RESP} state_e;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;   // 0 = A, 1 = B
    logic                    last_q, last_d;     // last granted port, 1 = B
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    // response registers, index 0 = A, 1 = B
    logic [1:0]              rvld_q, rvld_d;
    logic [1:0]              rerr_q, rerr_d;
    logic [1:0][DATA_W-1:0]  rdat_q, rdat_d;

    logic                    gnt_a, gnt_b;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    own_rsp_ready;

    // In round-robin mode A only loses a tie when it was granted last;
    // with FAIR=0 A wins every tie.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state_q == S_IDLE) begin
            gnt_a = a_req_valid & (~b_req_valid | ~FAIR | last_q);
            gnt_b = b_req_valid & ~gnt_a;
        end
    end

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;

    assign sel_we    = gnt_b ? b_req_we    : a_req_we;
    assign sel_addr  = gnt_b ? b_req_addr  : a_req_addr;
    assign sel_wdata = gnt_b ? b_req_wdata : a_req_wdata;

    assign own_rsp_ready = owner_q ? b_rsp_ready : a_rsp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rvld_d  = rvld_q;
        rerr_d  = rerr_q;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_a || gnt_b) begin
                    owner_d = gnt_b;
                    last_d  = gnt_b;
                    if (sel_addr >= DEPTH_A) begin
                        // Rejected: command registers keep their old values
                        // so the bad address never shows on mem_addr.
                        rdat_d[gnt_b] = '0;
                        rerr_d[gnt_b] = 1'b1;
                        rvld_d[gnt_b] = 1'b1;
                        state_d       = S_RESP;
                    end else begin
                        we_d    = sel_we;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        state_d = S_MEM;
                    end
                end
            end
            S_MEM: state_d = S_CAP;
            S_CAP: begin
                // Read data for the MEM-cycle address is on mem_rdata now;
                // for a write it is the word before the write.
                rdat_d[owner_q] = mem_rdata;
                rerr_d[owner_q] = 1'b0;
                rvld_d[owner_q] = 1'b1;
                state_d         = S_RESP;
            end
            S_RESP: begin
                if (own_rsp_ready) begin
                    rvld_d[owner_q] = 1'b0;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rvld_q  <= '0;
            rerr_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rvld_q  <= rvld_d;
            rerr_q  <= rerr_d;
            rdat_q  <= rdat_d;
        end
    end

    // Gated by rst_n so a reset landing in the MEM cycle cannot write.
    assign mem_we    = rst_n & (state_q == S_MEM) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign a_rsp_valid = rvld_q[0];
    assign a_rsp_err   = rerr_q[0];
    assign a_rsp_rdata = rdat_q[0];
    assign b_rsp_valid = rvld_q[1];
    assign b_rsp_err   = rerr_q[1];
    assign b_rsp_rdata = rdat_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed + randomized bench for dmem_arbiter. A behavioural memory sits on
// the memory port; a golden word array predicts every response.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req_valid = 0, a_req_we = 0, a_rsp_ready = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 0;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    // fixed-priority instance sharing the same request inputs
    logic        a0_req_ready, a0_rsp_valid, a0_rsp_err;
    logic        b0_req_ready, b0_rsp_valid, b0_rsp_err;
    logic [31:0] a0_rsp_rdata, b0_rsp_rdata, m0_addr, m0_wdata;
    logic        m0_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .FAIR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .FAIR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a0_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a0_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_rdata(a0_rsp_rdata), .a_rsp_err(a0_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b0_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b0_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_rdata(b0_rsp_rdata), .b_rsp_err(b0_rsp_err),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_we(m0_we),
        .mem_rdata(32'h0)
    );

    // behavioural memory: registered read, read-before-write
    logic [31:0] mem [0:1023];
    logic [31:0] gold [0:1023];
    logic        init_req = 1'b0;
    logic [31:0] seed = 32'h0;

    function automatic logic [31:0] fill(input int i, input logic [31:0] s);
        return (32'(i) * 32'h9E3779B1) ^ s;
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= fill(i, seed);
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[9:0]];
    end

    // observe every memory write
    int          we_cnt = 0;
    logic [31:0] last_we_addr = 0, last_we_data = 0;
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit p);
        return p ? b_req_ready : a_req_ready;
    endfunction
    function automatic logic rv(input bit p);
        return p ? b_rsp_valid : a_rsp_valid;
    endfunction
    function automatic logic [31:0] rd(input bit p);
        return p ? b_rsp_rdata : a_rsp_rdata;
    endfunction
    function automatic logic re(input bit p);
        return p ? b_rsp_err : a_rsp_err;
    endfunction

    task automatic set_req(input bit p, input logic v, input logic we,
                           input logic [31:0] ad, input logic [31:0] wd);
        if (p) begin
            b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = wd;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = wd;
        end
    endtask

    task automatic set_rr(input bit p, input logic v);
        if (p) b_rsp_ready = v; else a_rsp_ready = v;
    endtask

    // One transaction on port p; call at a negedge or just after a posedge
    // with the design idle. Returns at a negedge.
    task automatic do_txn(input bit p, input logic we, input logic [31:0] ad,
                          input logic [31:0] wd, input int hold);
        bit          legal = (ad < 32'd1024);
        logic [31:0] exp_rd = legal ? gold[ad[9:0]] : 32'h0;
        int          n = 0;
        int          lat = 0;
        int          wc0;
        set_rr(p, 1'b0);
        set_req(p, 1'b1, we, ad, wd);
        #1;
        while (!rdy(p) && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", rdy(p), 1'b1);
        if (!rdy(p)) begin
            set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        check("other_ready", rdy(!p), 1'b0);
        wc0 = we_cnt;
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
        do begin
            @(negedge clk);
            lat++;
            check("other_rsp_valid", rv(!p), 1'b0);
        end while (!rv(p) && lat < 8);
        check("latency", 32'(lat), legal ? 32'd3 : 32'd1);
        check("rsp_rdata", rd(p), exp_rd);
        check("rsp_err", {31'h0, re(p)}, {31'h0, !legal});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", rv(p), 1'b1);
            check("hold_rdata", rd(p), exp_rd);
        end
        set_rr(p, 1'b1);
        @(posedge clk); #1;
        set_rr(p, 1'b0);
        @(negedge clk);
        check("rsp_clear", rv(p), 1'b0);
        check("we_count", 32'(we_cnt - wc0), (legal && we) ? 32'd1 : 32'd0);
        if (legal && we) begin
            check("we_addr", last_we_addr, ad);
            check("we_data", last_we_data, wd);
            gold[ad[9:0]] = wd;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ad;
        logic [31:0] held;
        int          g1[$];
        int          g0[$];
        int          n;

        seed = $urandom;
        for (int i = 0; i < 1024; i++) gold[i] = fill(i, seed);

        // reset with memory preload
        init_req = 1'b1;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        check("rst_a_valid", a_rsp_valid, 1'b0);
        check("rst_b_valid", b_rsp_valid, 1'b0);
        check("rst_a_rdata", a_rsp_rdata, 32'h0);
        check("rst_b_rdata", b_rsp_rdata, 32'h0);
        check("rst_a_err", a_rsp_err, 1'b0);
        check("rst_b_err", b_rsp_err, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // A write then read back
        do_txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 0);
        do_txn(1'b0, 1'b0, 32'd5, 32'h0, 1);

        // write returns the old word
        do_txn(1'b0, 1'b1, 32'd7, 32'h11, 0);
        do_txn(1'b0, 1'b1, 32'd7, 32'h22, 0);
        check("old_word", a_rsp_rdata, 32'h11);
        do_txn(1'b0, 1'b0, 32'd7, 32'h0, 0);
        check("new_word", a_rsp_rdata, 32'h22);

        // range boundary on B
        do_txn(1'b1, 1'b0, 32'd1023, 32'h0, 0);
        do_txn(1'b1, 1'b1, 32'd1024, 32'h5555AAAA, 0);
        do_txn(1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 2);

        // response backpressure on A with B waiting
        set_req(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
        #1;
        check("bp_a_ready", a_req_ready, 1'b1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'd1023, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("bp_b_blocked", b_req_ready, 1'b0);
        end while (!a_rsp_valid && n < 8);
        check("bp_a_valid", a_rsp_valid, 1'b1);
        held = a_rsp_rdata;
        check("bp_rdata", held, gold[5]);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", a_rsp_valid, 1'b1);
            check("bp_hold_rdata", a_rsp_rdata, held);
            check("bp_b_blocked", b_req_ready, 1'b0);
        end
        a_rsp_ready = 1'b1;
        #1;
        check("bp_b_hs_cycle", b_req_ready, 1'b0);
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_a_clear", a_rsp_valid, 1'b0);
        check("bp_b_next", b_req_ready, 1'b1);
        do_txn(1'b1, 1'b0, 32'd1023, 32'h0, 0);

        // randomized traffic, one port at a time
        for (int t = 0; t < 40; t++) begin
            case ($urandom % 8)
                5:       ad = 32'd1023;
                6:       ad = 32'd1024 + ($urandom % 100);
                7:       ad = $urandom | 32'h80000000;
                default: ad = $urandom % 1024;
            endcase
            do_txn(1'($urandom % 2), 1'($urandom % 2), ad, $urandom, int'($urandom % 3));
        end

        // reset during the MEM cycle of a write to addr 9
        set_req(1'b0, 1'b1, 1'b1, 32'd9, 32'hA5A5A5A5);
        #1;
        check("mid_ready", a_req_ready, 1'b1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_a_valid", a_rsp_valid, 1'b0);
            check("mid_b_valid", b_rsp_valid, 1'b0);
        end
        do_txn(1'b0, 1'b0, 32'd9, 32'h0, 0);

        // contention: both ports request reads continuously
        apply_reset();
        set_req(1'b0, 1'b1, 1'b0, 32'd1, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'd2, 32'h0);
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("both_ready", {31'h0, a_req_ready & b_req_ready}, 32'h0);
            if (a_req_ready) g1.push_back(0);
            if (b_req_ready) g1.push_back(1);
            if (a0_req_ready) g0.push_back(0);
            if (b0_req_ready) g0.push_back(1);
        end
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rr_grants", 32'(g1.size()), 32'd5);
        for (int i = 0; i < g1.size() && i < 5; i++)
            check("rr_order", 32'(g1[i]), 32'(i % 2));
        check("fixed_grants", 32'(g0.size()), 32'd5);
        for (int i = 0; i < g0.size() && i < 5; i++)
            check("fixed_order", 32'(g0[i]), 32'd0);
        repeat (6) @(negedge clk);
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
